microprogramming: RTL and testbench
===================================

// Module: microprogramming
// PURPOSE
//  RV32I main control decoder for the single-issue core. Decodes Opcode/Funct3/Funct7 into
//  datapath controls: regfile write, ALU op, imm/mem muxes, memory access, branch/jump select.
//  Controls are registered: one cycle of latency into the execute-side datapath.
// PARAMETERS
//  OPCODE_LENGTH  7  opcode field width
//  FUNCT3_LENGTH  3  funct3 field width
//  FUNCT7_LENGTH  7  funct7 field width
// PORTS
//  clk                    in   1  clock; all outputs update on rising edge
//  rst_n                  in   1  reset, asynchronous, active-low
//  Opcode                 in   7  instr[6:0]
//  Funct3                 in   3  instr[14:12]
//  Funct7                 in   7  instr[31:25]
//  regWrite               out  1  write rd
//  immSelMux              out  1  1: ALU operand B = immediate; 0: rs2
//  LoadMux                out  1  1: writeback = memory data; 0: ALU result
//  MemRead                out  1  data memory read
//  MemWrite               out  1  data memory write
//  Con_Jalr               out  1  jump target = rs1+imm
//  BranchSig              out  1  conditional branch instruction
//  ALUSignal              out  4  ALU op code
//  SelSignalforBranchSel  out  2  next-PC select: 00 PC+4, 01 cond. branch, 10 JAL, 11 JALR
//  LoadstoreSigodecoder   out  3  mem access size/sign = Funct3 for load/store; else 000
// BEHAVIOUR
//  - Reset (rst_n=0, async): every output 0. First decode appears after first posedge with rst_n=1.
//  - Latency 1 cycle: outputs at edge N reflect inputs sampled at edge N. No handshake.
//  - ALUSignal: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, A PASSB;
//    B-F unused.
//  - R 0110011: regWrite; ALU from Funct3. 000: Funct7[5] ? SUB : ADD. 101: Funct7[5] ? SRA : SRL.
//  - I-ALU 0010011: regWrite, immSel. ALU from Funct3; 000 always ADD (Funct7 ignored).
//    101 uses Funct7[5] for SRAI/SRLI.
//  - LOAD 0000011: regWrite, immSel, LoadMux, MemRead; ADD; LS=Funct3.
//  - STORE 0100011: immSel, MemWrite; ADD; LS=Funct3.
//  - BRANCH 1100011: BranchSig, Sel=01. ALU: SUB for 000/001, SLT for 100/101, SLTU for 110/111.
//  - JAL 1101111: regWrite, Sel=10, ADD.
//  - JALR 1100111: regWrite, immSel, Con_Jalr, Sel=11, ADD.
//  - LUI 0110111: regWrite, immSel, PASSB.
//  - AUIPC 0010111: regWrite, immSel, ADD.
//  - Any other opcode: all outputs 0 (NOP, ADD, Sel=00). Never writes regs/memory.
//  - Reset asserted mid-stream clears outputs immediately, independent of clk.
// CONFIGURATION
//  ILLEGAL_INSN_CHECK_EN defined:
//    - Extra output illegal_insn (1 bit, registered, reset 0).
//    - Set for: unknown opcode; load Funct3 011/110/111; store Funct3 >010; branch Funct3 010/011;
//      JALR Funct3!=000; R-type Funct7 not 0000000/0100000 (0100000 only legal with 000/101);
//      SLLI Funct7!=0; SRLI/SRAI Funct7 not 0000000/0100000.
//    - On illegal_insn=1 all other outputs forced 0.
//  Not defined: no port. Reserved Funct3/Funct7 in known opcodes decode per table above.
//    Unknown opcode is still NOP.
// TESTING
//  1 rst_n=0, any inputs -> all outputs 0, also while clk toggles.
//  2 Opcode=0010011 F3=000 F7=0000000, one edge -> regWrite=1 immSel=1 ALU=0 others 0 Sel=00 LS=000.
//  3 Opcode=0110011 F3=000 F7=0100000 -> regWrite=1 immSel=0 ALU=1 (SUB); F3=101 same F7 -> ALU=7.
//  4 Opcode=0000011 F3=100 -> regWrite=1 immSel=1 LoadMux=1 MemRead=1 LS=100 ALU=0.
//    Opcode=0100011 F3=010 -> MemWrite=1 regWrite=0 LS=010.
//  5 Opcode=1100011 F3=110 -> BranchSig=1 Sel=01 ALU=4 regWrite=0.
//    1100111 -> Con_Jalr=1 Sel=11 regWrite=1. 1101111 -> Sel=10.
//  6 Opcode=1111111 -> all 0 (illegal_insn=1 with macro).
//    Inputs changed between edges -> outputs unchanged until next edge.

Source files
------------

// File: rtl/microprogramming_if.sv
// Decode bus between fetch and the main control decoder: instruction fields in, controls out.
// Pure wiring bundle, no storage; the decoder owns the output registers.
// Compile-time option ILLEGAL_INSN_CHECK_EN adds the illegal_insn flag to the bundle.
interface microprogramming_if #(
   parameter int OPCODE_LENGTH = 7,
   parameter int FUNCT3_LENGTH = 3,
   parameter int FUNCT7_LENGTH = 7
);
   logic [OPCODE_LENGTH-1:0] Opcode;
   logic [FUNCT3_LENGTH-1:0] Funct3;
   logic [FUNCT7_LENGTH-1:0] Funct7;
   logic                     regWrite;
   logic                     immSelMux;
   logic                     LoadMux;
   logic                     MemRead;
   logic                     MemWrite;
   logic                     Con_Jalr;
   logic                     BranchSig;
   logic [3:0]               ALUSignal;
   logic [1:0]               SelSignalforBranchSel;
   logic [2:0]               LoadstoreSigodecoder;
`ifdef ILLEGAL_INSN_CHECK_EN
   logic                     illegal_insn;
`endif

   // Fetch side: drives instruction fields, consumes controls.
   modport master (
      output Opcode, Funct3, Funct7,
      input  regWrite, immSelMux, LoadMux, MemRead, MemWrite, Con_Jalr, BranchSig,
             ALUSignal, SelSignalforBranchSel, LoadstoreSigodecoder
`ifdef ILLEGAL_INSN_CHECK_EN
      , input illegal_insn
`endif
   );

   // Decoder side: consumes instruction fields, drives controls.
   modport slave (
      input  Opcode, Funct3, Funct7,
      output regWrite, immSelMux, LoadMux, MemRead, MemWrite, Con_Jalr, BranchSig,
             ALUSignal, SelSignalforBranchSel, LoadstoreSigodecoder
`ifdef ILLEGAL_INSN_CHECK_EN
      , output illegal_insn
`endif
   );
endinterface

// File: rtl/microprogramming.sv
// RV32I main control decoder: Opcode/Funct3/Funct7 -> registered datapath controls.
// Latency 1 cycle (outputs at edge N reflect inputs sampled at edge N); no backpressure, decodes every cycle.
// Option ILLEGAL_INSN_CHECK_EN: flags reserved encodings on illegal_insn and forces all other controls to 0.
module microprogramming #(
   parameter int OPCODE_LENGTH = 7,
   parameter int FUNCT3_LENGTH = 3,
   parameter int FUNCT7_LENGTH = 7
) (
   input  logic                clk,
   input  logic                rst_n,
   microprogramming_if.slave   bus
);
   localparam logic [OPCODE_LENGTH-1:0] OP_R      = 7'b0110011;
   localparam logic [OPCODE_LENGTH-1:0] OP_I      = 7'b0010011;
   localparam logic [OPCODE_LENGTH-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_LENGTH-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_LENGTH-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_LENGTH-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_LENGTH-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPCODE_LENGTH-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPCODE_LENGTH-1:0] OP_AUIPC  = 7'b0010111;

   localparam logic [FUNCT7_LENGTH-1:0] F7_BASE   = 7'b0000000;
   localparam logic [FUNCT7_LENGTH-1:0] F7_ALT    = 7'b0100000;

   localparam logic [3:0] ALU_ADD   = 4'h0;
   localparam logic [3:0] ALU_SUB   = 4'h1;
   localparam logic [3:0] ALU_SLL   = 4'h2;
   localparam logic [3:0] ALU_SLT   = 4'h3;
   localparam logic [3:0] ALU_SLTU  = 4'h4;
   localparam logic [3:0] ALU_XOR   = 4'h5;
   localparam logic [3:0] ALU_SRL   = 4'h6;
   localparam logic [3:0] ALU_SRA   = 4'h7;
   localparam logic [3:0] ALU_OR    = 4'h8;
   localparam logic [3:0] ALU_AND   = 4'h9;
   localparam logic [3:0] ALU_PASSB = 4'hA;

   localparam logic [1:0] SEL_PC4  = 2'b00;
   localparam logic [1:0] SEL_BR   = 2'b01;
   localparam logic [1:0] SEL_JAL  = 2'b10;
   localparam logic [1:0] SEL_JALR = 2'b11;

   logic       reg_write_d;
   logic       imm_sel_d;
   logic       load_mux_d;
   logic       mem_read_d;
   logic       mem_write_d;
   logic       jalr_d;
   logic       branch_d;
   logic [3:0] alu_d;
   logic [1:0] sel_d;
   logic [2:0] ls_d;
   logic       illegal_d;

   logic [2:0] f3;
   logic       f7_alt_bit;

   assign f3         = bus.Funct3;
   assign f7_alt_bit = bus.Funct7[5];

   // Shared R/I-type ALU op from Funct3; add/sub split is handled by the caller.
   function automatic logic [3:0] alu_from_f3(input logic [2:0] fn3, input logic alt);
      logic [3:0] op;
      op = ALU_ADD;
      case (fn3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Next-cycle control decode from the current instruction fields.
   always_comb begin
      reg_write_d = 1'b0;
      imm_sel_d   = 1'b0;
      load_mux_d  = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      jalr_d      = 1'b0;
      branch_d    = 1'b0;
      alu_d       = ALU_ADD;
      sel_d       = SEL_PC4;
      ls_d        = 3'b000;
      illegal_d   = 1'b0;
      case (bus.Opcode)
         OP_R: begin
            reg_write_d = 1'b1;
            alu_d       = (f3 == 3'b000) ? (f7_alt_bit ? ALU_SUB : ALU_ADD)
                                         : alu_from_f3(f3, f7_alt_bit);
         end
         OP_I: begin
            reg_write_d = 1'b1;
            imm_sel_d   = 1'b1;
            alu_d       = alu_from_f3(f3, f7_alt_bit);
         end
         OP_LOAD: begin
            reg_write_d = 1'b1;
            imm_sel_d   = 1'b1;
            load_mux_d  = 1'b1;
            mem_read_d  = 1'b1;
            ls_d        = f3;
         end
         OP_STORE: begin
            imm_sel_d   = 1'b1;
            mem_write_d = 1'b1;
            ls_d        = f3;
         end
         OP_BRANCH: begin
            branch_d = 1'b1;
            sel_d    = SEL_BR;
            case (f3[2:1])
               2'b00, 2'b01: alu_d = ALU_SUB;
               2'b10:        alu_d = ALU_SLT;
               default:      alu_d = ALU_SLTU;
            endcase
         end
         OP_JAL: begin
            reg_write_d = 1'b1;
            sel_d       = SEL_JAL;
         end
         OP_JALR: begin
            reg_write_d = 1'b1;
            imm_sel_d   = 1'b1;
            jalr_d      = 1'b1;
            sel_d       = SEL_JALR;
         end
         OP_LUI: begin
            reg_write_d = 1'b1;
            imm_sel_d   = 1'b1;
            alu_d       = ALU_PASSB;
         end
         OP_AUIPC: begin
            reg_write_d = 1'b1;
            imm_sel_d   = 1'b1;
         end
         default: ;
      endcase

`ifdef ILLEGAL_INSN_CHECK_EN
      case (bus.Opcode)
         OP_LOAD:   illegal_d = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         OP_STORE:  illegal_d = (f3 > 3'b010);
         OP_BRANCH: illegal_d = (f3 == 3'b010) || (f3 == 3'b011);
         OP_JALR:   illegal_d = (f3 != 3'b000);
         OP_R: begin
            if (bus.Funct7 == F7_BASE)
               illegal_d = 1'b0;
            else if (bus.Funct7 == F7_ALT)
               illegal_d = !((f3 == 3'b000) || (f3 == 3'b101));
            else
               illegal_d = 1'b1;
         end
         OP_I: begin
            if (f3 == 3'b001)
               illegal_d = (bus.Funct7 != F7_BASE);
            else if (f3 == 3'b101)
               illegal_d = !((bus.Funct7 == F7_BASE) || (bus.Funct7 == F7_ALT));
         end
         OP_JAL, OP_LUI, OP_AUIPC: illegal_d = 1'b0;
         default:   illegal_d = 1'b1;
      endcase
      // A flagged instruction must not disturb architectural state.
      if (illegal_d) begin
         reg_write_d = 1'b0;
         imm_sel_d   = 1'b0;
         load_mux_d  = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         jalr_d      = 1'b0;
         branch_d    = 1'b0;
         alu_d       = ALU_ADD;
         sel_d       = SEL_PC4;
         ls_d        = 3'b000;
      end
`endif
   end

`ifndef ILLEGAL_INSN_CHECK_EN
   // Without the checker only Funct7[5] matters; the rest of the field and the flag are don't-cares.
   logic unused_bits;
   assign unused_bits = ^{bus.Funct7[6], bus.Funct7[4:0], illegal_d};
`endif

   // Control register stage; async reset clears every control immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.regWrite              <= 1'b0;
         bus.immSelMux             <= 1'b0;
         bus.LoadMux               <= 1'b0;
         bus.MemRead               <= 1'b0;
         bus.MemWrite              <= 1'b0;
         bus.Con_Jalr              <= 1'b0;
         bus.BranchSig             <= 1'b0;
         bus.ALUSignal             <= ALU_ADD;
         bus.SelSignalforBranchSel <= SEL_PC4;
         bus.LoadstoreSigodecoder  <= 3'b000;
`ifdef ILLEGAL_INSN_CHECK_EN
         bus.illegal_insn          <= 1'b0;
`endif
      end else begin
         bus.regWrite              <= reg_write_d;
         bus.immSelMux             <= imm_sel_d;
         bus.LoadMux               <= load_mux_d;
         bus.MemRead               <= mem_read_d;
         bus.MemWrite              <= mem_write_d;
         bus.Con_Jalr              <= jalr_d;
         bus.BranchSig             <= branch_d;
         bus.ALUSignal             <= alu_d;
         bus.SelSignalforBranchSel <= sel_d;
         bus.LoadstoreSigodecoder  <= ls_d;
`ifdef ILLEGAL_INSN_CHECK_EN
         bus.illegal_insn          <= illegal_d;
`endif
      end
   end
endmodule

// File: tb/tb_microprogramming.sv
// Scoreboard bench for the RV32I control decoder: stimulus pushes expected controls,
// a monitor pops and compares one entry per clock edge.
// Also covers async reset mid-stream and input changes between edges.
module tb_microprogramming;
   typedef struct packed {
      logic       rw;
      logic       imm;
      logic       ldm;
      logic       mr;
      logic       mw;
      logic       jalr;
      logic       br;
      logic [3:0] alu;
      logic [1:0] sel;
      logic [2:0] ls;
      logic       ill;
   } ctrl_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      ctrl_t      exp;
      string      name;
   } vec_t;

   logic clk;
   logic rst_n;
   microprogramming_if bus ();

   microprogramming dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int     errors = 0;
   int     checks = 0;
   ctrl_t  exp_q[$];
   string  name_q[$];
   ctrl_t  actual;
   vec_t   vecs[$];

   always_comb begin
      actual = '0;
      actual.rw   = bus.regWrite;
      actual.imm  = bus.immSelMux;
      actual.ldm  = bus.LoadMux;
      actual.mr   = bus.MemRead;
      actual.mw   = bus.MemWrite;
      actual.jalr = bus.Con_Jalr;
      actual.br   = bus.BranchSig;
      actual.alu  = bus.ALUSignal;
      actual.sel  = bus.SelSignalforBranchSel;
      actual.ls   = bus.LoadstoreSigodecoder;
`ifdef ILLEGAL_INSN_CHECK_EN
      actual.ill  = bus.illegal_insn;
`endif
   end

   function automatic ctrl_t mk(input logic rw, input logic imm, input logic ldm, input logic mr,
                                input logic mw, input logic jalr, input logic br,
                                input logic [3:0] alu, input logic [1:0] sel, input logic [2:0] ls,
                                input logic ill);
      ctrl_t c;
      c.rw = rw; c.imm = imm; c.ldm = ldm; c.mr = mr; c.mw = mw; c.jalr = jalr; c.br = br;
      c.alu = alu; c.sel = sel; c.ls = ls;
`ifdef ILLEGAL_INSN_CHECK_EN
      c.ill = ill;
`else
      c.ill = 1'b0 & ill;
`endif
      return c;
   endfunction

   task automatic check(input string name, input ctrl_t got, input ctrl_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input ctrl_t exp);
      vec_t v;
      v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.exp = exp;
      vecs.push_back(v);
   endtask

   // Drive one instruction at the falling edge and queue what the next rising edge must produce.
   task automatic issue(input vec_t v);
      @(negedge clk);
      bus.Opcode = v.op;
      bus.Funct3 = v.f3;
      bus.Funct7 = v.f7;
      exp_q.push_back(v.exp);
      name_q.push_back(v.name);
   endtask

   // Monitor: every rising edge with a queued expectation is compared just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) check(name_q.pop_front(), actual, exp_q.pop_front());
      end
   end

   ctrl_t zero_c;
   vec_t  v;

   initial begin
      zero_c = '0;
      //       name          opcode      f3      f7          rw imm ldm mr mw jr br alu   sel    ls    ill
      add_vec("addi",       7'b0010011, 3'b000, 7'b0000000, mk(1,1,0,0,0,0,0,4'h0,2'b00,3'b000,0));
      add_vec("sub",        7'b0110011, 3'b000, 7'b0100000, mk(1,0,0,0,0,0,0,4'h1,2'b00,3'b000,0));
      add_vec("sra",        7'b0110011, 3'b101, 7'b0100000, mk(1,0,0,0,0,0,0,4'h7,2'b00,3'b000,0));
      add_vec("add",        7'b0110011, 3'b000, 7'b0000000, mk(1,0,0,0,0,0,0,4'h0,2'b00,3'b000,0));
      add_vec("and",        7'b0110011, 3'b111, 7'b0000000, mk(1,0,0,0,0,0,0,4'h9,2'b00,3'b000,0));
      add_vec("lbu",        7'b0000011, 3'b100, 7'b0000000, mk(1,1,1,1,0,0,0,4'h0,2'b00,3'b100,0));
      add_vec("sw",         7'b0100011, 3'b010, 7'b0000000, mk(0,1,0,0,1,0,0,4'h0,2'b00,3'b010,0));
      add_vec("bltu",       7'b1100011, 3'b110, 7'b0000000, mk(0,0,0,0,0,0,1,4'h4,2'b01,3'b000,0));
      add_vec("beq",        7'b1100011, 3'b000, 7'b0000000, mk(0,0,0,0,0,0,1,4'h1,2'b01,3'b000,0));
      add_vec("bge",        7'b1100011, 3'b101, 7'b0000000, mk(0,0,0,0,0,0,1,4'h3,2'b01,3'b000,0));
      add_vec("jalr",       7'b1100111, 3'b000, 7'b0000000, mk(1,1,0,0,0,1,0,4'h0,2'b11,3'b000,0));
      add_vec("jal",        7'b1101111, 3'b000, 7'b0000000, mk(1,0,0,0,0,0,0,4'h0,2'b10,3'b000,0));
      add_vec("auipc",      7'b0010111, 3'b000, 7'b0000000, mk(1,1,0,0,0,0,0,4'h0,2'b00,3'b000,0));
      add_vec("srai",       7'b0010011, 3'b101, 7'b0100000, mk(1,1,0,0,0,0,0,4'h7,2'b00,3'b000,0));
      add_vec("addi_f7",    7'b0010011, 3'b000, 7'b0100000, mk(1,1,0,0,0,0,0,4'h0,2'b00,3'b000,0));
      add_vec("sltiu",      7'b0010011, 3'b011, 7'b0000000, mk(1,1,0,0,0,0,0,4'h4,2'b00,3'b000,0));
      add_vec("unknown_op", 7'b1111111, 3'b111, 7'b1111111, mk(0,0,0,0,0,0,0,4'h0,2'b00,3'b000,1));
      add_vec("lui",        7'b0110111, 3'b000, 7'b0000000, mk(1,1,0,0,0,0,0,4'hA,2'b00,3'b000,0));

      // Reset held while clocks run and a live instruction sits on the bus.
      rst_n = 1'b0;
      bus.Opcode = 7'b0110011;
      bus.Funct3 = 3'b000;
      bus.Funct7 = 7'b0100000;
      #2;
      check("reset_async", actual, zero_c);
      for (int i = 0; i < 3; i++) begin
         v.name = "reset_hold"; v.op = 7'b0000011; v.f3 = 3'b100; v.f7 = 7'b0; v.exp = zero_c;
         issue(v);
      end
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) issue(vecs[i]);

      // Outputs must hold the last decode (LUI) while inputs change between edges.
      @(posedge clk);
      #2;
      bus.Opcode = 7'b0000011;
      bus.Funct3 = 3'b010;
      #2;
      check("hold_between_edges", actual, vecs[vecs.size()-1].exp);

      // Async reset mid-stream clears controls without waiting for a clock edge.
      issue(vecs[0]);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("reset_midstream", actual, zero_c);
      @(negedge clk);
      rst_n = 1'b1;
      issue(vecs[6]);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end
endmodule
